disp_panel_ctrl: RTL and testbench

- Registered, parametrised successor to the combinational cab display logic.
- Drives three things: an animated door-opening LED bar of any even width, a 7-segment floor digit for up to 9 floors, and up/down direction indicators.
- Sits between the elevator controller FSM (door command, one-hot position, mode) and the panel pins.
- Door animation is timed by a step counter and reverses cleanly mid-motion.

---
 rtl/disp_panel_pkg.sv | 23 ++
 rtl/disp_door_anim.sv | 105 ++++++++++
 rtl/disp_panel_ctrl.sv | 117 +++++++++++
 tb/tb_disp_panel_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_panel_pkg.sv
// Shared types and constants for the cab display panel controller.
package disp_panel_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_state_t;

  localparam logic [1:0] UD_IDLE = 2'b00;
  localparam logic [1:0] UD_UP   = 2'b01;
  localparam logic [1:0] UD_DOWN = 2'b10;

  // Segment patterns {a,b,c,d,e,f,g}, index = displayed digit
  localparam logic [6:0] SEG_DIGIT [1:9] = '{
    7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  localparam logic [6:0] SEG_RESET = 7'b0110000;

endpackage

// File: rtl/disp_door_anim.sv
// Door LED bar animation: FSM, per-step tick counter, open level and
// centre-outward LED pattern. All outputs registered.
module disp_door_anim
  import disp_panel_pkg::*;
#(
  parameter int DOOR_WIDTH = 6,
  parameter int STEP_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  door_cmd,
  output logic [DOOR_WIDTH-1:0] door_led,
  output logic                  door_is_open,
  output logic                  door_is_closed
);

  localparam int HALF = DOOR_WIDTH / 2;
  localparam int LW   = $clog2(HALF + 1);
  localparam int CW   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] TERM  = CW'(STEP_TICKS - 1);
  localparam logic [LW-1:0] LVL_F = LW'(HALF);

  door_state_t           state, state_n;
  logic [LW-1:0]         level, level_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DOOR_WIDTH-1:0] led_n;

  // Next state: step through levels, reverse in place when door_cmd flips
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = cnt;
    case (state)
      CLOSED: begin
        if (door_cmd) begin
          state_n = OPENING;
          cnt_n   = '0;
        end
      end
      OPENING: begin
        if (!door_cmd) begin
          // Nothing opened yet: reversing lands directly at rest
          cnt_n   = '0;
          state_n = (level == '0) ? CLOSED : CLOSING;
        end else if (cnt == TERM) begin
          cnt_n   = '0;
          level_n = level + LW'(1);
          if (level_n == LVL_F) state_n = OPEN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      OPEN: begin
        if (!door_cmd) begin
          state_n = CLOSING;
          cnt_n   = '0;
        end
      end
      CLOSING: begin
        if (door_cmd) begin
          cnt_n   = '0;
          state_n = (level == LVL_F) ? OPEN : OPENING;
        end else if (level == '0) begin
          state_n = CLOSED;
        end else if (cnt == TERM) begin
          cnt_n   = '0;
          level_n = level - LW'(1);
          if (level_n == '0) state_n = CLOSED;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = CLOSED;
    endcase
  end

  // LED pattern for the next level: dark band HALF-level .. HALF+level-1
  always_comb begin
    led_n = '1;
    for (int i = 0; i < DOOR_WIDTH; i++) begin
      if (i >= HALF - int'(level_n) && i <= HALF + int'(level_n) - 1)
        led_n[i] = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CLOSED;
      level          <= '0;
      cnt            <= '0;
      door_led       <= '1;
      door_is_open   <= 1'b0;
      door_is_closed <= 1'b1;
    end else begin
      state          <= state_n;
      level          <= level_n;
      cnt            <= cnt_n;
      door_led       <= led_n;
      door_is_open   <= (state_n == OPEN);
      door_is_closed <= (state_n == CLOSED);
    end
  end

endmodule

// File: rtl/disp_panel_ctrl.sv
// Cab display panel: door LED animation, floor 7-segment digit and
// direction indicators. Define DISP_BLINK_EN for blinking indicators.
module disp_panel_ctrl
  import disp_panel_pkg::*;
#(
  parameter int NUM_FLOORS  = 4,
  parameter int DOOR_WIDTH  = 6,
  parameter int STEP_TICKS  = 4,
  parameter int BLINK_TICKS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  door_cmd,
  input  logic [NUM_FLOORS-1:0] position,
  input  logic [1:0]            ud_mode,
  output logic [DOOR_WIDTH-1:0] door_led,
  output logic                  door_is_open,
  output logic                  door_is_closed,
  output logic [6:0]            floor_seg,
  output logic                  dir_up,
  output logic                  dir_down
);

  if (NUM_FLOORS < 2 || NUM_FLOORS > 9) begin : g_bad_floors
    $error("disp_panel_ctrl: NUM_FLOORS must be 2..9");
  end
  if (DOOR_WIDTH < 2 || (DOOR_WIDTH % 2) != 0) begin : g_bad_width
    $error("disp_panel_ctrl: DOOR_WIDTH must be even and >= 2");
  end
  if (STEP_TICKS < 1 || BLINK_TICKS < 1) begin : g_bad_ticks
    $error("disp_panel_ctrl: STEP_TICKS and BLINK_TICKS must be >= 1");
  end

  disp_door_anim #(
    .DOOR_WIDTH (DOOR_WIDTH),
    .STEP_TICKS (STEP_TICKS)
  ) u_door (
    .clk            (clk),
    .rst            (rst),
    .door_cmd       (door_cmd),
    .door_led       (door_led),
    .door_is_open   (door_is_open),
    .door_is_closed (door_is_closed)
  );

  logic       pos_onehot;
  logic [6:0] seg_n;

  // Floor digit: only a clean one-hot position replaces the shown digit
  always_comb begin
    pos_onehot = (position != '0) &&
                 ((position & (position - NUM_FLOORS'(1))) == '0);
    seg_n = floor_seg;
    if (pos_onehot) begin
      for (int f = 0; f < NUM_FLOORS; f++) begin
        if (position[f]) seg_n = SEG_DIGIT[4'(f + 1)];
      end
    end
  end

  // Floor digit register
  always_ff @(posedge clk) begin
    if (rst) floor_seg <= SEG_RESET;
    else     floor_seg <= seg_n;
  end

`ifdef DISP_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BTERM = BW'(BLINK_TICKS - 1);

  logic [1:0]    mode_q;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          phase, phase_n;   // 0 = lit half-period

  // Blink timer restarts lit whenever the requested mode changes
  always_comb begin
    bcnt_n  = bcnt + BW'(1);
    phase_n = phase;
    if (ud_mode != mode_q) begin
      bcnt_n  = '0;
      phase_n = 1'b0;
    end else if (bcnt == BTERM) begin
      bcnt_n  = '0;
      phase_n = ~phase;
    end
  end

  // Blinking indicators, gated by the lit phase
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= UD_IDLE;
      bcnt     <= '0;
      phase    <= 1'b0;
      dir_up   <= 1'b0;
      dir_down <= 1'b0;
    end else begin
      mode_q   <= ud_mode;
      bcnt     <= bcnt_n;
      phase    <= phase_n;
      dir_up   <= (ud_mode == UD_UP)   && !phase_n;
      dir_down <= (ud_mode == UD_DOWN) && !phase_n;
    end
  end
`else
  // Steady indicators; reserved mode 11 shows nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_up   <= 1'b0;
      dir_down <= 1'b0;
    end else begin
      dir_up   <= (ud_mode == UD_UP);
      dir_down <= (ud_mode == UD_DOWN);
    end
  end
`endif

endmodule

// File: tb/tb_disp_panel_ctrl.sv
// Self-checking bench for disp_panel_ctrl: directed door sequences, a
// floor/direction vector table and randomized traffic against a model.
module tb_disp_panel_ctrl;

  localparam int NF = 4, DW = 6, ST = 4, BT = 8, HALF = DW / 2;

  logic          clk = 1'b0;
  logic          rst, door_cmd;
  logic [NF-1:0] position;
  logic [8:0]    position9;
  logic [1:0]    ud_mode;
  logic [DW-1:0] door_led;
  logic          door_is_open, door_is_closed, dir_up, dir_down;
  logic [6:0]    floor_seg;
  logic [DW-1:0] led9;
  logic          open9, closed9, up9, down9;
  logic [6:0]    seg9;

  always #5 clk = ~clk;

  disp_panel_ctrl #(.NUM_FLOORS(NF), .DOOR_WIDTH(DW), .STEP_TICKS(ST), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .door_cmd(door_cmd), .position(position), .ud_mode(ud_mode),
    .door_led(door_led), .door_is_open(door_is_open), .door_is_closed(door_is_closed),
    .floor_seg(floor_seg), .dir_up(dir_up), .dir_down(dir_down));

  disp_panel_ctrl #(.NUM_FLOORS(9), .DOOR_WIDTH(DW), .STEP_TICKS(ST), .BLINK_TICKS(BT)) dut9 (
    .clk(clk), .rst(rst), .door_cmd(door_cmd), .position(position9), .ud_mode(ud_mode),
    .door_led(led9), .door_is_open(open9), .door_is_closed(closed9),
    .floor_seg(seg9), .dir_up(up9), .dir_down(down9));

  int ncmp = 0, nbad = 0;
  logic [6:0] seg_tbl [10];

  // Reference model state
  int m_lvl, m_mov, m_tick, m_prev, m_age;
  logic [6:0] m_seg, m_seg9;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] led_of(input int lvl);
    logic [DW-1:0] v = '1;
    for (int i = HALF - lvl; i < HALF + lvl; i++) v[i] = 1'b0;
    return v;
  endfunction

  task automatic model_edge();
    int dir;
    if (rst) begin
      m_lvl = 0; m_mov = 0; m_tick = 0; m_prev = 0; m_age = 0;
      m_seg = seg_tbl[1]; m_seg9 = seg_tbl[1];
      return;
    end
    dir = door_cmd ? 1 : -1;
    if (m_mov != dir) begin
      if ((dir == 1 && m_lvl == HALF) || (dir == -1 && m_lvl == 0)) m_mov = 0;
      else begin m_mov = dir; m_tick = 0; end
    end else begin
      m_tick++;
      if (m_tick == ST) begin
        m_lvl += dir; m_tick = 0;
        if (m_lvl == 0 || m_lvl == HALF) m_mov = 0;
      end
    end
    if ($countones(position) == 1)
      for (int f = 0; f < NF; f++) if (position[f]) m_seg = seg_tbl[f + 1];
    if ($countones(position9) == 1)
      for (int f = 0; f < 9; f++) if (position9[f]) m_seg9 = seg_tbl[f + 1];
    if (int'(ud_mode) != m_prev) begin m_prev = int'(ud_mode); m_age = 0; end
    else m_age++;
  endtask

  // One clock: advance the model on the edge, then compare every output
  task automatic step();
    logic lit;
    @(posedge clk);
    model_edge();
    #1;
`ifdef DISP_BLINK_EN
    lit = ((m_age / BT) % 2) == 0;
`else
    lit = 1'b1;
`endif
    chk("m_door_led", door_led, led_of(m_lvl));
    chk("m_open", door_is_open, m_mov == 0 && m_lvl == HALF);
    chk("m_closed", door_is_closed, m_mov == 0 && m_lvl == 0);
    chk("m_seg", floor_seg, m_seg);
    chk("m_seg9", seg9, m_seg9);
    chk("m_up", dir_up, m_prev == 1 && lit);
    chk("m_down", dir_down, m_prev == 2 && lit);
  endtask

  typedef struct {
    logic [NF-1:0] pos;
    logic [1:0]    ud;
    logic [6:0]    seg;
    logic          up, down;
  } vec_t;

  typedef struct {
    logic [8:0] pos;
    logic [6:0] seg;
  } vec9_t;

  logic [DW-1:0] pat [4];

  initial begin
    vec_t  vt [8];
    vec9_t v9 [4];
    seg_tbl = '{7'b0, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    pat = '{6'b111111, 6'b110011, 6'b100001, 6'b000000};
    vt = '{
      '{4'b0001, 2'b01, 7'b0110000, 1'b1, 1'b0},
      '{4'b0100, 2'b01, 7'b1111001, 1'b1, 1'b0},
      '{4'b0000, 2'b10, 7'b1111001, 1'b0, 1'b1},
      '{4'b0110, 2'b11, 7'b1111001, 1'b0, 1'b0},
      '{4'b1000, 2'b00, 7'b0110011, 1'b0, 1'b0},
      '{4'b0010, 2'b10, 7'b1101101, 1'b0, 1'b1},
      '{4'b1111, 2'b01, 7'b1101101, 1'b1, 1'b0},
      '{4'b0001, 2'b11, 7'b0110000, 1'b0, 1'b0}};
    v9 = '{'{9'h100, 7'b1111011}, '{9'h000, 7'b1111011},
           '{9'h040, 7'b1110000}, '{9'h003, 7'b1110000}};

    rst = 1; door_cmd = 0; position = '0; position9 = '0; ud_mode = 2'b00;
    step(); step();
    chk("rst_led", door_led, 6'b111111);
    chk("rst_seg", floor_seg, 7'b0110000);
    chk("rst_closed", door_is_closed, 1'b1);
    chk("rst_open", door_is_open, 1'b0);
    chk("rst_dir", {dir_up, dir_down}, 2'b00);
    rst = 0;
    step();

    // Full open then full close
    door_cmd = 1; step();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("open_seq", door_led, pat[k / 4]);
      if (k >= 11) chk("open_flag", door_is_open, k == 12);
    end
    door_cmd = 0; step();
    chk("close_start", door_led, pat[3]);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("close_seq", door_led, pat[3 - k / 4]);
    end
    chk("close_flag", door_is_closed, 1'b1);

    // Reversal at level 1
    door_cmd = 1; step();
    for (int k = 1; k <= 4; k++) step();
    chk("rev_l1", door_led, pat[1]);
    door_cmd = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("rev_seq", door_led, (k == 5) ? pat[0] : pat[1]);
    end
    chk("rev_closed", door_is_closed, 1'b1);

    // Reset while opening at level 2, door_cmd held high
    door_cmd = 1; step();
    for (int k = 1; k <= 8; k++) step();
    chk("mid_l2", door_led, pat[2]);
    rst = 1; step();
    chk("mid_rst_led", door_led, pat[0]);
    chk("mid_rst_closed", door_is_closed, 1'b1);
    rst = 0; step();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("reopen", door_led, (k == 4) ? pat[1] : pat[0]);
    end
    door_cmd = 0;
    for (int k = 0; k < 8; k++) step();

    // Floor / direction vector table
    foreach (vt[i]) begin
      position = vt[i].pos; ud_mode = vt[i].ud;
      step();
      chk("tbl_seg", floor_seg, vt[i].seg);
      chk("tbl_up", dir_up, vt[i].up);
      chk("tbl_down", dir_down, vt[i].down);
    end
    foreach (v9[i]) begin
      position9 = v9[i].pos;
      step();
      chk("tbl_seg9", seg9, v9[i].seg);
    end

`ifdef DISP_BLINK_EN
    // Blink timing: lit 8, dark 8, then switch direction
    ud_mode = 2'b01;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("blink_up", dir_up, (k % 16) < 8);
    end
    ud_mode = 2'b10; step();
    chk("blink_sw", {dir_up, dir_down}, 2'b01);
`endif

    // Randomized traffic checked against the model inside step()
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(11) == 0) door_cmd = ~door_cmd;
      position  = ($urandom_range(2) == 0) ? NF'($urandom) : NF'(1 << $urandom_range(NF - 1));
      position9 = ($urandom_range(2) == 0) ? 9'($urandom) : 9'(1 << $urandom_range(8));
      if ($urandom_range(23) == 0) ud_mode = 2'($urandom);
      rst = ($urandom_range(299) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
